serial_io_sched: RTL

//  Scheduler for the board's two serial display chains: the 16-bit LED shift chain
//  and the 64-bit 7-seg chain ({SEG7E,SEG7}). A single shift engine is shared between them.

---
 rtl/serial_io_sched_pkg.sv | 28 ++
 rtl/serial_io_sched_shift_engine.sv | 96 +++++++++
 rtl/serial_io_sched.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/serial_io_sched_pkg.sv
// Shared constants and types for the serial display scheduler.
//   state_t : scheduler FSM encoding (IDLE/LOAD/SHIFT/LATCH)
//   ch_t    : engine owner IDs (CH_LED=0, CH_SEG=1)
//   *_DEF   : default chain widths and sclk half-period
package serial_io_sched_pkg;

  localparam int unsigned LED_W_DEF    = 16;
  localparam int unsigned SEG_W_DEF    = 64;
  localparam int unsigned HALF_PER_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  typedef enum logic {
    CH_LED = 1'b0,
    CH_SEG = 1'b1
  } ch_t;

  // One-hot grant vector for a channel: [0]=LED, [1]=SEG.
  function automatic logic [1:0] ch_onehot(input ch_t ch);
    return (ch == CH_LED) ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/serial_io_sched_shift_engine.sv
// Generic MSB-first serial shifter shared by both display chains.
// A 1-cycle start captures din (left-aligned) and len; each bit spans
// 2*HALF_PER clk cycles, sclk high in the second half so the rising edge
// lands mid-bit. done is high during the final cycle of the last bit.
//   clk, rst_n : clock, async active-low reset
//   start      : load din/len and begin shifting
//   len        : number of bits to shift (1..MAX_W)
//   din        : data, MSB at din[MAX_W-1]
//   sclk, sdat : registered serial clock / data (0 when inactive)
//   done       : registered, high in the last cycle of the frame
module serial_io_sched_shift_engine #(
  parameter int unsigned MAX_W    = 64,
  parameter int unsigned HALF_PER = 4,
  localparam int unsigned LEN_W   = $clog2(MAX_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [MAX_W-1:0] din,
  output logic             sclk,
  output logic             sdat,
  output logic             done
);

  localparam int unsigned   PH_W    = $clog2(2 * HALF_PER);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(HALF_PER);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * HALF_PER - 1);

  logic             active, active_n;
  logic [MAX_W-1:0] shreg, shreg_n;
  logic [PH_W-1:0]  phase, phase_n;
  logic [LEN_W-1:0] bit_cnt, bit_cnt_n;
  logic [LEN_W-1:0] len_q, len_q_n;
  logic             sclk_n, sdat_n, done_n;

  // Next-state for the bit/phase counters and serial outputs.
  always_comb begin
    active_n  = active;
    shreg_n   = shreg;
    phase_n   = phase;
    bit_cnt_n = bit_cnt;
    len_q_n   = len_q;
    sclk_n    = 1'b0;
    sdat_n    = 1'b0;
    done_n    = 1'b0;
    if (start) begin
      active_n  = 1'b1;
      len_q_n   = len;
      phase_n   = '0;
      bit_cnt_n = '0;
      sdat_n    = din[MAX_W-1];
      shreg_n   = din << 1;
    end else if (active) begin
      if (phase == PH_LAST) begin
        if (bit_cnt == len_q - LEN_W'(1)) begin
          // Frame over: clock and data park low.
          active_n = 1'b0;
        end else begin
          phase_n   = '0;
          bit_cnt_n = bit_cnt + LEN_W'(1);
          sdat_n    = shreg[MAX_W-1];
          shreg_n   = shreg << 1;
        end
      end else begin
        phase_n = phase + PH_W'(1);
        sdat_n  = sdat;
        sclk_n  = (phase_n >= PH_HALF);
      end
      done_n = active_n && (phase_n == PH_LAST) && (bit_cnt_n == len_q - LEN_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      shreg   <= '0;
      phase   <= '0;
      bit_cnt <= '0;
      len_q   <= '0;
      sclk    <= 1'b0;
      sdat    <= 1'b0;
      done    <= 1'b0;
    end else begin
      active  <= active_n;
      shreg   <= shreg_n;
      phase   <= phase_n;
      bit_cnt <= bit_cnt_n;
      len_q   <= len_q_n;
      sclk    <= sclk_n;
      sdat    <= sdat_n;
      done    <= done_n;
    end
  end

endmodule

// File: rtl/serial_io_sched.sv
// Scheduler for the LED (16-bit) and 7-seg (64-bit) serial display chains
// sharing one shift engine. A chain becomes pending when its word differs
// from the last shifted snapshot or on refresh; pending chains are served
// round-robin. Frame: LOAD (1) + SHIFT (2*HALF_PER*W) + LATCH (HALF_PER).
//   clk, resetn          : clock, async active-low reset
//   led_data, seg_data   : words to display
//   refresh              : 1-cycle strobe, marks both chains pending
//   led_clk/dat/en/clr   : LED chain pins (clr active-low)
//   seg_clk/dat/en/clr   : 7-seg chain pins
//   busy                 : frame in progress
//   grant                : one-hot engine owner, [0]=LED [1]=SEG
module serial_io_sched
  import serial_io_sched_pkg::*;
#(
  parameter int unsigned LED_W    = LED_W_DEF,
  parameter int unsigned SEG_W    = SEG_W_DEF,
  parameter int unsigned HALF_PER = HALF_PER_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [LED_W-1:0] led_data,
  input  logic [SEG_W-1:0] seg_data,
  input  logic             refresh,
  output logic             led_clk,
  output logic             led_dat,
  output logic             led_en,
  output logic             led_clr,
  output logic             seg_clk,
  output logic             seg_dat,
  output logic             seg_en,
  output logic             seg_clr,
  output logic             busy,
  output logic [1:0]       grant
);

  localparam int unsigned MAX_W = (SEG_W > LED_W) ? SEG_W : LED_W;
  localparam int unsigned LEN_W = $clog2(MAX_W + 1);
  localparam int unsigned LAT_W = $clog2(HALF_PER);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(HALF_PER - 1);

  state_t           state, state_n;
  ch_t              owner, owner_n, last_grant;
  logic [LAT_W-1:0] lat_cnt, lat_cnt_n;
  logic             led_en_n, seg_en_n, busy_n;
  logic [1:0]       grant_n;

  logic [LED_W-1:0] shadow_led;
  logic [SEG_W-1:0] shadow_seg;
  logic             pend_led, pend_seg, clr_q;
  logic             load_led_c, load_seg_c, set_led_c, set_seg_c;

  logic             start_c;
  logic [LEN_W-1:0] len_c;
  logic [MAX_W-1:0] din_c;
  logic             eng_sclk, eng_sdat, eng_done;

  // Pending-flag set/clear terms. The LOAD of a channel refreshes its
  // shadow, so a mismatch in that cycle is not a new change; refresh still
  // wins over the clear.
  always_comb begin
    load_led_c = (state == ST_LOAD) && (owner == CH_LED);
    load_seg_c = (state == ST_LOAD) && (owner == CH_SEG);
    set_led_c  = refresh || ((led_data != shadow_led) && !load_led_c);
    set_seg_c  = refresh || ((seg_data != shadow_seg) && !load_seg_c);
  end

  // Shadows, pending flags, round-robin memory and chain clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shadow_led <= '0;
      shadow_seg <= '0;
      pend_led   <= 1'b1;
      pend_seg   <= 1'b1;
      last_grant <= CH_SEG;
      clr_q      <= 1'b0;
    end else begin
      clr_q    <= 1'b1;
      pend_led <= set_led_c || (pend_led && !load_led_c);
      pend_seg <= set_seg_c || (pend_seg && !load_seg_c);
      if (load_led_c) shadow_led <= led_data;
      if (load_seg_c) shadow_seg <= seg_data;
      if (state == ST_LOAD) last_grant <= owner;
    end
  end

  // FSM next-state and registered-output values.
  always_comb begin
    state_n   = state;
    owner_n   = owner;
    lat_cnt_n = lat_cnt;
    led_en_n  = led_en;
    seg_en_n  = seg_en;
    case (state)
      ST_IDLE: begin
        if (pend_led || pend_seg) begin
          state_n = ST_LOAD;
          if (pend_led && pend_seg) owner_n = (last_grant == CH_SEG) ? CH_LED : CH_SEG;
          else                      owner_n = pend_led ? CH_LED : CH_SEG;
        end
      end
      ST_LOAD: begin
        state_n = ST_SHIFT;
        if (owner == CH_LED) led_en_n = 1'b0;
        else                 seg_en_n = 1'b0;
      end
      ST_SHIFT: begin
        if (eng_done) begin
          state_n   = ST_LATCH;
          lat_cnt_n = '0;
          if (owner == CH_LED) led_en_n = 1'b1;
          else                 seg_en_n = 1'b1;
        end
      end
      ST_LATCH: begin
        if (lat_cnt == LAT_LAST) state_n = ST_IDLE;
        else                     lat_cnt_n = lat_cnt + LAT_W'(1);
      end
      default: state_n = ST_IDLE;
    endcase
    busy_n  = (state_n != ST_IDLE);
    grant_n = busy_n ? ch_onehot(owner_n) : 2'b00;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      owner   <= CH_LED;
      lat_cnt <= '0;
      led_en  <= 1'b0;
      seg_en  <= 1'b0;
      busy    <= 1'b0;
      grant   <= 2'b00;
    end else begin
      state   <= state_n;
      owner   <= owner_n;
      lat_cnt <= lat_cnt_n;
      led_en  <= led_en_n;
      seg_en  <= seg_en_n;
      busy    <= busy_n;
      grant   <= grant_n;
    end
  end

  // Engine load: LED word left-aligned so its MSB leaves first.
  assign start_c = (state == ST_LOAD);
  assign din_c   = (owner == CH_LED) ? (MAX_W'(led_data) << (MAX_W - LED_W)) : MAX_W'(seg_data);
  assign len_c   = (owner == CH_LED) ? LEN_W'(LED_W) : LEN_W'(SEG_W);

  serial_io_sched_shift_engine #(
    .MAX_W   (MAX_W),
    .HALF_PER(HALF_PER)
  ) u_engine (
    .clk  (clk),
    .rst_n(resetn),
    .start(start_c),
    .len  (len_c),
    .din  (din_c),
    .sclk (eng_sclk),
    .sdat (eng_sdat),
    .done (eng_done)
  );

  // Steering: grant only changes while the engine clock is parked low,
  // so gating with it cannot produce a runt pulse on the chain clocks.
  assign led_clk = eng_sclk & grant[0];
  assign led_dat = eng_sdat & grant[0];
  assign seg_clk = eng_sclk & grant[1];
  assign seg_dat = eng_sdat & grant[1];
  assign led_clr = clr_q;
  assign seg_clr = clr_q;

endmodule
